// File: rtl/layer1_global_pool_pkg.sv
// Shared constants and types for the layer-1 global pooling stage.
package layer1_global_pool_pkg;

    localparam int DATA_W   = 13;               // unsigned 9.4 pixel
    localparam int ADDR_W   = 12;
    localparam int NUM_PIX  = 1024;
    localparam int LOG2_PIX = 10;
    localparam int SUM_W    = DATA_W + LOG2_PIX; // 1024 * 8191 fits, no overflow

    // Bank select values shared with the conv stage.
    localparam logic CSEL_L0 = 1'b0;
    localparam logic CSEL_L1 = 1'b1;

    // State encodings.
    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_READ  = 2'd1;
    localparam logic [1:0] ENC_DRAIN = 2'd2;
    localparam logic [1:0] ENC_FINAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        READ  = ENC_READ,
        DRAIN = ENC_DRAIN,
        FINAL = ENC_FINAL
    } state_t;

endpackage

// File: rtl/layer1_global_pool_if.sv
// Handshake, memory read port and result bus of the global pooling stage.
interface layer1_global_pool_if;

    logic                                         start;
    logic                                         busy;
    logic                                         done;
    logic                                         crd;
    logic [layer1_global_pool_pkg::ADDR_W-1:0]    caddr_rd;
    logic [layer1_global_pool_pkg::DATA_W-1:0]    cdata_rd;
    logic                                         csel;
    logic [layer1_global_pool_pkg::DATA_W-1:0]    avg_out;
    logic [layer1_global_pool_pkg::DATA_W-1:0]    max_out;
    logic [layer1_global_pool_pkg::LOG2_PIX-1:0]  max_idx;

    // Pooling block side.
    modport slave (
        input  start, cdata_rd,
        output busy, done, crd, caddr_rd, csel, avg_out, max_out, max_idx
    );

    // Controller / memory side.
    modport master (
        output start, cdata_rd,
        input  busy, done, crd, caddr_rd, csel, avg_out, max_out, max_idx
    );

endinterface

// File: rtl/layer1_global_pool_max_accum_unit.sv
// Running sum and first-occurrence max/argmax over a stream of pixels.
// Exposes the next-state values so the caller can capture the final
// result on the same edge that absorbs the last word.
module max_accum_unit
    import layer1_global_pool_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_valid,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [LOG2_PIX-1:0] i_idx,
    output logic [SUM_W-1:0]    o_sum_next,
    output logic [DATA_W-1:0]   o_max_next,
    output logic [LOG2_PIX-1:0] o_idx_next
);

    logic [SUM_W-1:0]    r_sum;
    logic [DATA_W-1:0]   r_max;
    logic [LOG2_PIX-1:0] r_idx;
    logic                r_first;

    // Fold one word in: strict compare keeps the lowest address on ties,
    // and the first word always seeds the max even when it is zero.
    always_comb begin
        o_sum_next = r_sum;
        o_max_next = r_max;
        o_idx_next = r_idx;
        if (i_valid) begin
            o_sum_next = r_sum + SUM_W'(i_data);
            if (r_first || (i_data > r_max)) begin
                o_max_next = i_data;
                o_idx_next = i_idx;
            end
        end
    end

    // Accumulator registers; clear wins over a coincident valid word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum   <= '0;
            r_max   <= '0;
            r_idx   <= '0;
            r_first <= 1'b1;
        end else if (i_clear) begin
            r_sum   <= '0;
            r_max   <= '0;
            r_idx   <= '0;
            r_first <= 1'b1;
        end else if (i_valid) begin
            r_sum   <= o_sum_next;
            r_max   <= o_max_next;
            r_idx   <= o_idx_next;
            r_first <= 1'b0;
        end
    end

endmodule

// File: rtl/layer1_global_pool.sv
// Streams the whole layer-1 bank and reports global average, max and
// first argmax, with a start/busy/done handshake.
module layer1_global_pool
    import layer1_global_pool_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    layer1_global_pool_if.slave  bus
);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_start_acc;
    logic                w_last_issue;

    logic [ADDR_W-1:0]   r_caddr;
    logic                r_crd;
    logic                r_csel;
    logic                r_busy;
    logic                r_done;
    logic                r_rd_vld;     // a read was issued last cycle
    logic [LOG2_PIX-1:0] r_rd_idx;     // address of the word now on cdata_rd
    logic [DATA_W-1:0]   r_avg;
    logic [DATA_W-1:0]   r_max;
    logic [LOG2_PIX-1:0] r_max_idx;

    logic [SUM_W-1:0]    w_sum_next;
    logic [DATA_W-1:0]   w_max_next;
    logic [LOG2_PIX-1:0] w_idx_next;
    logic [DATA_W-1:0]   w_avg;

    // Round-half-up average of the final sum; the result always fits DATA_W.
    assign w_avg = DATA_W'((w_sum_next + SUM_W'(NUM_PIX / 2)) >> LOG2_PIX);

    max_accum_unit u_accum (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_start_acc),
        .i_valid    (r_rd_vld),
        .i_data     (bus.cdata_rd),
        .i_idx      (r_rd_idx),
        .o_sum_next (w_sum_next),
        .o_max_next (w_max_next),
        .o_idx_next (w_idx_next)
    );

    // Next-state decode: start only matters in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_last_issue = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = READ;
                end
            end
            READ: begin
                if (r_caddr == ADDR_W'(NUM_PIX - 1)) begin
                    w_last_issue = 1'b1;
                    w_state_next = DRAIN;
                end
            end
            DRAIN:   w_state_next = FINAL;
            FINAL:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Read-port sequencing and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_caddr   <= '0;
            r_crd     <= 1'b0;
            r_csel    <= CSEL_L0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_idx  <= '0;
            r_avg     <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
        end else begin
            r_rd_vld <= r_crd;
            if (r_crd) r_rd_idx <= r_caddr[LOG2_PIX-1:0];
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_acc) begin
                        r_caddr <= '0;
                        r_crd   <= 1'b1;
                        r_csel  <= CSEL_L1;
                        r_busy  <= 1'b1;
                    end
                end
                READ: begin
                    // Drop the read port as soon as the last address has
                    // been presented so crd spans exactly NUM_PIX cycles.
                    if (w_last_issue) begin
                        r_crd  <= 1'b0;
                        r_csel <= CSEL_L0;
                    end else begin
                        r_caddr <= r_caddr + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last word is absorbed on this edge; capture the
                    // results from the accumulator's next values.
                    r_avg     <= w_avg;
                    r_max     <= w_max_next;
                    r_max_idx <= w_idx_next;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.crd      = r_crd;
    assign bus.caddr_rd = r_caddr;
    assign bus.csel     = r_csel;
    assign bus.avg_out  = r_avg;
    assign bus.max_out  = r_max;
    assign bus.max_idx  = r_max_idx;

endmodule
